shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter; the successor of the 32-bit combinational shifter.
- Adds rotate modes, configurable width, one register per shift stage, a valid/ready handshake with backpressure, and a zero flag.
- Sits between the ALU operand muxes and the writeback staging. It is the shift unit for multi-cycle execute and is reusable at any power-of-two width.

Parameters:
- WIDTH, 32, data width. Must be a power of two, at least 4.
- SAW, $clog2(WIDTH), shift-amount width. Derived; do not override.
- L, SAW, number of pipeline stages. Derived; equals fixed latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand presented
- in_ready  output  1  block accepts operand this cycle
- x  input  WIDTH  operand
- sa  input  SAW  shift amount, 0..WIDTH-1
- mode  input  3  bit0 = right, bit1 = arith, bit2 = rotate
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- sh  output  WIDTH  result
- zero  output  1  sh == 0

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Modes:
  - 000 SLL; 001 SRL; 011 SRA; 010 treated as SLL (arith ignored for left).
  - 100 ROL; 101 ROR; 11x treated as ROL/ROR (arith ignored for rotate).
- Fill rules:
  - Logical shifts fill with 0.
  - SRA fills with x[WIDTH-1] captured at acceptance.
  - Rotates wrap shifted-out bits into the vacated end.
- Stage structure:
  - Stage i (i = 1..L) conditionally shifts by 2^(L-i), MSB first (e.g. 16, 8, 4, 2, 1 for WIDTH=32), controlled by sa bit L-i.
  - Each stage registers: data, remaining sa bits, mode, sign bit, and a valid bit v[i].
- Handshake:
  - Transfer at input occurs when in_valid && in_ready; at output when out_valid && out_ready.
  - out_valid = v[L]. sh and zero are driven from stage-L registers; zero is computed combinationally from sh.
- Stall and advance rule (per stage, bubble-collapsing):
  - adv[L] = v[L] && out_ready.
  - Stage i<L moves into i+1 when v[i] && (!v[i+1] || adv[i+1]).
  - in_ready = !v[1] || (stage 1 moves).
  - A stage not advancing holds its data and valid.
  - A stage that empties and receives nothing clears its valid.
- Latency and throughput:
  - Latency is exactly L cycles from acceptance to out_valid with no backpressure.
  - Throughput is 1 result/cycle.
- Backpressure: with out_ready low, up to L results are buffered; in_ready drops only when all L stages are full.
- Ordering: results leave in acceptance order. Results are never dropped or duplicated.
- sa = 0: the result equals x in every mode.
- Reset:
  - Clears all v[i] to 0, which drives out_valid to 0.
  - Clears all stage data to 0, so sh = 0 and zero = 1.
  - in_ready = 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight operands. An operand offered during the reset cycle is not accepted.
- Stable-output rule: while out_valid && !out_ready, sh and zero must hold stable.
- Simultaneous accept and emit with all stages full is legal; the pipeline shifts by one and stays full.

Test Plan:
- WIDTH=32, serial ops with out_ready=1:
  - SLL x=0x80000001 sa=1 -> sh=0x00000002 after 5 cycles.
  - SRL x=0x80000000 sa=31 -> 0x00000001.
  - SRA same operand -> 0xFFFFFFFF.
  - mode 010 x=0x80000001 sa=1 -> 0x00000002.
- Rotates:
  - ROR x=0x00000001 sa=4 -> 0x10000000.
  - ROL x=0xF0000000 sa=8 -> 0x000000F0.
  - Any mode with sa=0 x=0xDEADBEEF -> 0xDEADBEEF.
  - SLL x=0x00000001 sa=31 -> 0x80000000.
  - SRL x=0x00000001 sa=1 -> 0, with zero=1.
- Backpressure: stream 8 operands (SLL x=1, sa=0..7) with out_ready=0.
  - in_ready falls after 5 acceptances.
  - Raise out_ready: results appear in order as 1, 2, 4, ..., 128 with no gaps or duplicates.
  - sh is held stable during stall.
- Reset mid-flight: accept 3 operands, assert rst for 1 cycle.
  - The next cycle shows out_valid=0, sh=0, zero=1, in_ready=1.
  - None of the 3 results is ever emitted.
- Parameter sweep WIDTH=8 (L=3), random x/sa/mode with random in_valid/out_ready, checked against a reference model.
  - Example: SRA x=0x90 sa=2 -> 0xE4; ROR x=0x81 sa=1 -> 0xC0; latency exactly 3 cycles.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: one conditional power-of-two shift per stage,
// MSB amount first, with a bubble-collapsing valid/ready pipeline and a zero flag.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int SAW   = $clog2(WIDTH),
    parameter int L     = SAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [SAW-1:0]   sa,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sh,
    output logic             zero
);

    // Stage registers, index 1 = first stage after the input.
    logic [WIDTH-1:0] data_r [1:L];
    logic [SAW-1:0]   sa_r   [1:L];
    logic [2:0]       mode_r [1:L];
    logic             sign_r [1:L];
    logic [L:1]       v_r;

    // Source of each stage: the block inputs for stage 1, the previous stage otherwise.
    logic [WIDTH-1:0] src_data_s [1:L];
    logic [SAW-1:0]   src_sa_s   [1:L];
    logic [2:0]       src_mode_s [1:L];
    logic             src_sign_s [1:L];
    logic [WIDTH-1:0] shifted_s  [1:L];

    logic [L:1]       adv_s;
    logic [L:1]       load_s;
    logic             room_s;
    logic             in_ready_s;

    // One stage step: shift/rotate d by amt when en is set. mode bit0 = right,
    // bit2 = rotate, bit1 (arith) only matters for a non-rotating right shift.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input int               amt,
        input logic [2:0]       m,
        input logic             sgn
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        fill = {WIDTH{sgn}} << (WIDTH - amt);
        r    = d;
        if (en) begin
            case ({m[2], m[0]})
                2'b00:   r = d << amt;
                2'b01:   r = m[1] ? ((d >> amt) | fill) : (d >> amt);
                2'b10:   r = (d << amt) | (d >> (WIDTH - amt));
                2'b11:   r = (d >> amt) | (d << (WIDTH - amt));
                default: r = d;
            endcase
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Stage sources and the conditional shift each stage would capture.
    always_comb begin
        src_data_s[1] = x;
        src_sa_s[1]   = sa;
        src_mode_s[1] = mode;
        src_sign_s[1] = x[WIDTH-1];
        for (int i = 2; i <= L; i++) begin
            src_data_s[i] = data_r[i-1];
            src_sa_s[i]   = sa_r[i-1];
            src_mode_s[i] = mode_r[i-1];
            src_sign_s[i] = sign_r[i-1];
        end
        for (int i = 1; i <= L; i++) begin
            shifted_s[i] = shift_step(src_data_s[i], src_sa_s[i][L-i], 1 << (L - i),
                                      src_mode_s[i], src_sign_s[i]);
        end
    end

    // Advance chain: a stage moves when any later stage is empty or the output drains.
    always_comb begin
        adv_s  = '0;
        room_s = out_ready;
        for (int i = L; i >= 1; i--) begin
            adv_s[i] = v_r[i] & room_s;
            room_s   = room_s | ~v_r[i];
        end
    end

    // Load enables: stage 1 loads on an input transfer, later stages when their predecessor moves.
    always_comb begin
        load_s     = '0;
        in_ready_s = ~v_r[1] | adv_s[1];
        load_s[1]  = in_valid & in_ready_s;
        for (int i = 2; i <= L; i++) begin
            load_s[i] = adv_s[i-1];
        end
    end

    // Pipeline state: load, empty, or hold each stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '0;
            for (int i = 1; i <= L; i++) begin
                data_r[i] <= '0;
                sa_r[i]   <= '0;
                mode_r[i] <= 3'b000;
                sign_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i <= L; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= shifted_s[i];
                    sa_r[i]   <= src_sa_s[i];
                    mode_r[i] <= src_mode_s[i];
                    sign_r[i] <= src_sign_s[i];
                    v_r[i]    <= 1'b1;
                end else if (adv_s[i]) begin
                    v_r[i]    <= 1'b0;
                end else begin
                    v_r[i]    <= v_r[i];
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_r[L];
    assign sh        = data_r[L];
    assign zero      = ~|data_r[L];

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe at WIDTH=32 (directed) and WIDTH=8 (random).
module tb_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv32, ir32, ov32, or32, z32;
    logic [31:0] x32, sh32;
    logic [4:0]  sa32;
    logic [2:0]  mode32;
    logic        iv8, ir8, ov8, or8, z8;
    logic [7:0]  x8, sh8;
    logic [2:0]  sa8;
    logic [2:0]  mode8;

    shifter_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .x(x32), .sa(sa32),
        .mode(mode32), .out_valid(ov32), .out_ready(or32), .sh(sh32), .zero(z32)
    );

    shifter_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .sa(sa8),
        .mode(mode8), .out_valid(ov8), .out_ready(or8), .sh(sh8), .zero(z8)
    );

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          nout32 = 0;
    logic        acc32 = 1'b0, acc8 = 1'b0;
    logic        lat32 = 1'b0, lat8 = 1'b0;
    logic        hold32 = 1'b0, hold8 = 1'b0;
    logic [31:0] held32, held8;
    logic        heldz32, heldz8;
    logic [31:0] next_exp32, next_exp8;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference: result bit j is picked from its source bit of x.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] xv, input int s,
                                              input logic [2:0] m);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < w; j++) begin
            if (m[2])             r[j] = m[0] ? xv[(j + s) % w] : xv[(j - s + w) % w];
            else if (!m[0])       r[j] = (j >= s) ? xv[j - s] : 1'b0;
            else if (j + s < w)   r[j] = xv[j + s];
            else                  r[j] = m[1] ? xv[w - 1] : 1'b0;
        end
        return r;
    endfunction

    task automatic mon32();
        exp_t e;
        acc32 = 1'b0;
        if (rst) begin
            q32.delete();
            hold32 = 1'b0;
        end else begin
            if (hold32) begin
                check_eq("hold_sh32", sh32, held32);
                check_eq("hold_zero32", 32'(z32), 32'(heldz32));
                check_eq("hold_valid32", 32'(ov32), 32'd1);
            end
            if (iv32 && ir32) begin
                q32.push_back('{next_exp32, cyc});
                acc32 = 1'b1;
            end
            if (ov32 && or32) begin
                nout32++;
                if (q32.size() == 0) begin
                    check_eq("unexpected_out32", 32'(q32.size()), 32'd1);
                end else begin
                    e = q32.pop_front();
                    check_eq("sh32", sh32, e.d);
                    check_eq("zero32", 32'(z32), 32'(e.d == 32'd0));
                    if (lat32) check_eq("latency32", 32'(cyc - e.c), 32'd5);
                end
            end
            hold32  = ov32 && !or32;
            held32  = sh32;
            heldz32 = z32;
        end
    endtask

    task automatic mon8();
        exp_t e;
        acc8 = 1'b0;
        if (rst) begin
            q8.delete();
            hold8 = 1'b0;
        end else begin
            if (hold8) begin
                check_eq("hold_sh8", 32'(sh8), held8);
                check_eq("hold_zero8", 32'(z8), 32'(heldz8));
            end
            if (iv8 && ir8) begin
                q8.push_back('{next_exp8, cyc});
                acc8 = 1'b1;
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    check_eq("unexpected_out8", 32'(q8.size()), 32'd1);
                end else begin
                    e = q8.pop_front();
                    check_eq("sh8", 32'(sh8), e.d);
                    check_eq("zero8", 32'(z8), 32'(e.d == 32'd0));
                    if (lat8) check_eq("latency8", 32'(cyc - e.c), 32'd3);
                end
            end
            hold8  = ov8 && !or8;
            held8  = 32'(sh8);
            heldz8 = z8;
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon32();
        mon8();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic serial32(input logic [31:0] xv, input logic [4:0] s, input logic [2:0] m,
                            input logic [31:0] e);
        int n;
        x32 = xv; sa32 = s; mode32 = m; next_exp32 = e; iv32 = 1'b1;
        step();
        check_eq("accept32", 32'(acc32), 32'd1);
        iv32 = 1'b0;
        n = 0;
        while (q32.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check_eq("drain32", 32'(q32.size()), 32'd0);
    endtask

    task automatic serial8(input logic [7:0] xv, input logic [2:0] s, input logic [2:0] m,
                           input logic [7:0] e);
        int n;
        x8 = xv; sa8 = s; mode8 = m; next_exp8 = 32'(e); iv8 = 1'b1;
        step();
        check_eq("accept8", 32'(acc8), 32'd1);
        iv8 = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check_eq("drain8", 32'(q8.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int n;
        rst = 1'b1;
        iv32 = 1'b0; or32 = 1'b1; x32 = '0; sa32 = '0; mode32 = '0; next_exp32 = '0;
        iv8  = 1'b0; or8  = 1'b1; x8  = '0; sa8  = '0; mode8  = '0; next_exp8  = '0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_out_valid32", 32'(ov32), 32'd0);
        check_eq("rst_sh32", sh32, 32'd0);
        check_eq("rst_zero32", 32'(z32), 32'd1);
        check_eq("rst_in_ready32", 32'(ir32), 32'd1);
        check_eq("rst_out_valid8", 32'(ov8), 32'd0);
        check_eq("rst_zero8", 32'(z8), 32'd1);

        // Serial directed operations, latency checked.
        lat32 = 1'b1;
        serial32(32'h8000_0001, 5'd1,  3'b000, 32'h0000_0002);
        serial32(32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001);
        serial32(32'h8000_0000, 5'd31, 3'b011, 32'hFFFF_FFFF);
        serial32(32'h8000_0001, 5'd1,  3'b010, 32'h0000_0002);
        serial32(32'h0000_0001, 5'd4,  3'b101, 32'h1000_0000);
        serial32(32'hF000_0000, 5'd8,  3'b100, 32'h0000_00F0);
        serial32(32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000);
        serial32(32'h0000_0001, 5'd1,  3'b001, 32'h0000_0000);
        serial32(32'h8000_0001, 5'd3,  3'b111, 32'h3000_0000);
        for (int m = 0; m < 8; m++) begin
            serial32(32'hDEAD_BEEF, 5'd0, 3'(m), 32'hDEAD_BEEF);
        end

        // Backpressure: fill with out_ready low, then release.
        lat32 = 1'b0;
        or32 = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            x32 = 32'd1; sa32 = 5'(idx); mode32 = 3'b000; next_exp32 = 32'd1 << idx; iv32 = 1'b1;
            step();
            if (acc32) idx++;
        end
        check_eq("bp_accepts", 32'(idx), 32'd5);
        check_eq("bp_in_ready_low", 32'(ir32), 32'd0);
        check_eq("bp_out_valid", 32'(ov32), 32'd1);
        or32 = 1'b1;
        nout32 = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 8) begin
                sa32 = 5'(idx); next_exp32 = 32'd1 << idx; iv32 = 1'b1;
            end else begin
                iv32 = 1'b0;
            end
            step();
            if (acc32) idx++;
        end
        iv32 = 1'b0;
        check_eq("bp_no_gaps", 32'(nout32), 32'd8);
        check_eq("bp_all_accepted", 32'(idx), 32'd8);
        check_eq("bp_drained", 32'(q32.size()), 32'd0);

        // Reset with three operands in flight, one more offered during reset.
        for (int c = 0; c < 3; c++) begin
            x32 = 32'h0000_0100 << c; sa32 = 5'd4; mode32 = 3'b001;
            next_exp32 = 32'h0000_0010 << c; iv32 = 1'b1;
            step();
            check_eq("rst_flight_accept", 32'(acc32), 32'd1);
        end
        rst = 1'b1;
        x32 = 32'h1234_5678;
        step();
        rst = 1'b0;
        iv32 = 1'b0;
        check_eq("midrst_out_valid", 32'(ov32), 32'd0);
        check_eq("midrst_sh", sh32, 32'd0);
        check_eq("midrst_zero", 32'(z32), 32'd1);
        check_eq("midrst_in_ready", 32'(ir32), 32'd1);
        nout32 = 0;
        for (int c = 0; c < 10; c++) step();
        check_eq("midrst_no_output", 32'(nout32), 32'd0);

        // WIDTH=8 directed then random traffic against the reference model.
        lat8 = 1'b1;
        serial8(8'h90, 3'd2, 3'b011, 8'hE4);
        serial8(8'h81, 3'd1, 3'b101, 8'hC0);
        serial8(8'h81, 3'd1, 3'b110, 8'h03);
        lat8 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!iv8 || acc8) begin
                iv8 = ($urandom_range(0, 3) != 0);
                x8 = 8'($urandom);
                sa8 = 3'($urandom_range(0, 7));
                mode8 = 3'($urandom_range(0, 7));
                next_exp8 = ref_shift(8, {24'h0, x8}, int'(sa8), mode8);
            end
            or8 = ($urandom_range(0, 3) != 0);
            step();
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        n = 0;
        while (q8.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check_eq("rand_drained8", 32'(q8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
